rvs_xrf_wb_queue: RTL
=====================

Name: rvs_xrf_wb_queue

Overview:
- Parametrised retire-side buffer between RVV retire (`NUM_RT_UOP` XRF writeback lanes) and the scalar core's XRF write ports (`NUM_XRF_WP`).
- Generalises the fixed lane-to-port valid/ready path: decoupling FIFO, in-order multi-port drain, x0 filtering, same-cycle WAW suppression, occupancy/idle reporting.
- Sits inside the RVS-side wrapper, fed by the backend's rt_xrf_* lanes.

Parameters:
- NUM_RT_UOP, 4, XRF writeback lanes from retire; lane 0 is oldest.
- NUM_XRF_WP, 2, XRF write ports toward the scalar core.
- DEPTH, 8, FIFO entries; power of 2, ≥ NUM_RT_UOP.
- XLEN, 32, data width.
- RD_W, 5, register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wb_valid  in  NUM_RT_UOP  lane valid.
- wb_rd  in  NUM_RT_UOP*RD_W  destination register per lane.
- wb_data  in  NUM_RT_UOP*XLEN  write data per lane.
- wb_ready  out  NUM_RT_UOP  lane accepted.
- xrf_valid  out  NUM_XRF_WP  port presents an entry.
- xrf_we  out  NUM_XRF_WP  real write enable; 0 means WAW-suppressed.
- xrf_rd  out  NUM_XRF_WP*RD_W  write address.
- xrf_data  out  NUM_XRF_WP*XLEN  write data.
- xrf_ready  in  NUM_XRF_WP  scalar core accepts port.
- occupancy  out  $clog2(DEPTH)+1  entries held.
- idle  out  1  FIFO empty and no wb_valid.

Behaviour:
- Reset (rst=1 at posedge): head=tail=0, occupancy=0.
  - Outputs after reset: xrf_valid=0, xrf_we=0, xrf_rd=0, xrf_data=0.
  - wb_ready is combinational and equals 1 for all lanes while occupancy=0.
  - A reset mid-drain discards all entries; no partial write is retained.
- Enqueue:
  - need[i] = number of lanes j ≤ i with wb_valid[j]=1 and wb_rd[j]≠0.
  - wb_ready[i] = (need[i] ≤ free), where free = DEPTH − occupancy + pops_this_cycle is not used; free = DEPTH − occupancy (registered value only, no pop-to-push forwarding).
  - The accepted set is always a prefix in lane order; a lane is never accepted ahead of an older rejected lane.
  - Lanes with wb_rd=0 and valid: ready = ready of the previous lane (1 for lane 0); they are dropped without consuming a slot.
  - Accepted entries are written at tail in lane order; tail += count; tail wraps mod DEPTH.
- Drain (registered, 1-cycle minimum latency from accept to xrf_valid):
  - Port k presents entry head+k when k < occupancy; otherwise xrf_valid[k]=0.
  - pop = length of the contiguous prefix of ports with xrf_valid[k]&xrf_ready[k]. A port whose ready is high after an unready lower port is not popped.
  - head += pop, wrapping mod DEPTH.
  - Outputs are stable while valid&!ready. Each entry is presented in order exactly once per acceptance.
- WAW suppression:
  - Among valid ports in one cycle, port k has xrf_we=0 if any higher port m>k presents the same rd.
  - The suppressed port is still popped normally when its handshake completes, so only the youngest write to an rd reaches the XRF.
- Occupancy: occupancy_next = occupancy + pushed − popped.
  - Simultaneous push and pop are legal.
  - Push never exceeds free.
  - occupancy never exceeds DEPTH and never goes below 0.
  - A full FIFO drives wb_ready=0 for every lane needing a slot.
- Idle: idle = (occupancy==0) & ~|wb_valid, combinational.

Optional Feature:
- Macro: RVS_XRF_WB_BYPASS_EN.
- Defined:
  - When occupancy=0, accepted lanes also drive xrf_* combinationally in the same cycle (0-cycle latency), lane i → port i for i < NUM_XRF_WP.
  - Bypassed entries that are popped that cycle are not written into the FIFO.
  - Entries not popped are enqueued normally.
  - WAW suppression also applies to bypassed entries.
- Undefined: fixed 1-cycle minimum latency; no combinational path from wb_* to xrf_*.

Test Plan:
- Reset, 4 lanes valid (rd=1,2,3,4; data=0xA..0xD), xrf_ready=2'b11 → cycle+1: ports show rd1/rd2; cycle+2: ports show rd3/rd4; occupancy sequence 4,2,0; idle=1 after.
- Fill to DEPTH=8 with xrf_ready=0, then wb_valid=4'b1111 → wb_ready=0000. Release xrf_ready=2'b01 → exactly one entry drains per cycle; wb_ready[0]=1 in the following cycle.
- Lanes rd=0, rd=5, rd=0, rd=6 valid with empty FIFO → all ready=1; occupancy becomes 2; the XRF sees only rd5 and rd6.
- Two entries with rd=7 (data 0x11 then 0x22) presented on ports 0/1 → xrf_we=2'b10; both popped; the final XRF value is 0x22.
- xrf_ready=2'b10 with 2 entries → pop=0 and head unchanged. Then 2'b11 → pop=2.
- Assert rst while occupancy=5 → next cycle occupancy=0, xrf_valid=0, idle=1 with no wb_valid. With RVS_XRF_WB_BYPASS_EN and an empty FIFO: lane0 rd=9 with xrf_ready[0]=1 → xrf_valid[0]=1 in the same cycle and occupancy stays 0.

Source files
------------

// File: rtl/rvs_xrf_wb_queue.sv
// rvs_xrf_wb_queue: retire-side XRF writeback queue between RVV retire lanes and scalar XRF write ports
// Ports: clk, rst (sync active-high)
//   wb_valid/wb_rd/wb_data -> wb_ready   : NUM_RT_UOP retire lanes, lane 0 oldest, accepted as a prefix
//   xrf_valid/xrf_we/xrf_rd/xrf_data <- xrf_ready : NUM_XRF_WP ports, in-order drain, we=0 marks a WAW-shadowed write
//   occupancy, idle                       : entries held, empty-and-quiet flag
// Optional: RVS_XRF_WB_BYPASS_EN enables a 0-cycle path from accepted lanes to ports while the FIFO is empty.
module rvs_xrf_wb_queue #(
    parameter int NUM_RT_UOP = 4,
    parameter int NUM_XRF_WP = 2,
    parameter int DEPTH      = 8,
    parameter int XLEN       = 32,
    parameter int RD_W       = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RT_UOP-1:0]      wb_valid,
    input  logic [NUM_RT_UOP*RD_W-1:0] wb_rd,
    input  logic [NUM_RT_UOP*XLEN-1:0] wb_data,
    output logic [NUM_RT_UOP-1:0]      wb_ready,
    output logic [NUM_XRF_WP-1:0]      xrf_valid,
    output logic [NUM_XRF_WP-1:0]      xrf_we,
    output logic [NUM_XRF_WP*RD_W-1:0] xrf_rd,
    output logic [NUM_XRF_WP*XLEN-1:0] xrf_data,
    input  logic [NUM_XRF_WP-1:0]      xrf_ready,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [RD_W-1:0] r_mem_rd [DEPTH];
    logic [XLEN-1:0] r_mem_data [DEPTH];
    logic [AW-1:0] r_head, r_tail;
    logic [CW-1:0] r_occ;
    logic [CW-1:0] w_need [NUM_RT_UOP];
    logic [NUM_RT_UOP-1:0] w_take;
    logic [CW-1:0] w_cnt, w_push, w_pop, w_fpop, w_byp;
    logic [RD_W-1:0] w_prd [NUM_XRF_WP];
    logic [XLEN-1:0] w_pdata [NUM_XRF_WP];
    logic w_go;
    // need counts slot-consuming lanes up to and including lane i; monotonic, so readiness is a prefix
    always_comb begin
        w_cnt = '0;
        w_push = '0;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            w_cnt = w_cnt + CW'(wb_valid[i] && (wb_rd[i*RD_W +: RD_W] != '0));
            w_need[i] = w_cnt;
            wb_ready[i] = w_cnt <= (CW'(DEPTH) - r_occ);
            w_take[i] = wb_valid[i] && (wb_rd[i*RD_W +: RD_W] != '0) && wb_ready[i];
            w_push = w_push + CW'(w_take[i]);
        end
    end
    // port k shows entry head+k; pop only the contiguous handshaken prefix
    always_comb begin
        w_pop = '0;
        w_go = 1'b1;
        xrf_valid = '0;
        xrf_we = '0;
        xrf_rd = '0;
        xrf_data = '0;
        for (int k = 0; k < NUM_XRF_WP; k++) begin
            xrf_valid[k] = CW'(k) < r_occ;
            w_prd[k] = xrf_valid[k] ? r_mem_rd[r_head + AW'(k)] : '0;
            w_pdata[k] = xrf_valid[k] ? r_mem_data[r_head + AW'(k)] : '0;
`ifdef RVS_XRF_WB_BYPASS_EN
            if (r_occ == '0) begin
                xrf_valid[k] = w_take[k];
                w_prd[k] = w_take[k] ? wb_rd[k*RD_W +: RD_W] : '0;
                w_pdata[k] = w_take[k] ? wb_data[k*XLEN +: XLEN] : '0;
            end
`endif
            w_go = w_go && xrf_valid[k] && xrf_ready[k];
            w_pop = w_pop + CW'(w_go);
        end
        // an older port is shadowed by any younger port writing the same rd
        for (int k = 0; k < NUM_XRF_WP; k++) begin
            xrf_we[k] = xrf_valid[k];
            for (int m = k + 1; m < NUM_XRF_WP; m++)
                if (xrf_valid[m] && (w_prd[m] == w_prd[k])) xrf_we[k] = 1'b0;
            xrf_rd[k*RD_W +: RD_W] = w_prd[k];
            xrf_data[k*XLEN +: XLEN] = w_pdata[k];
        end
    end
`ifdef RVS_XRF_WB_BYPASS_EN
    // with an empty FIFO every pop is a bypassed lane that never lands in storage
    assign w_byp = (r_occ == '0) ? w_pop : '0;
`else
    assign w_byp = '0;
`endif
    assign w_fpop = w_pop - w_byp;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ <= '0;
        end else begin
            r_head <= r_head + AW'(w_fpop);
            r_tail <= r_tail + AW'(w_push - w_byp);
            r_occ <= r_occ + w_push - w_byp - w_fpop;
        end
    end
    // accepted lanes are a prefix, so lane i is the need[i]-th accepted entry
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            if (!rst && w_take[i] && (w_need[i] > w_byp)) begin
                r_mem_rd[r_tail + AW'(w_need[i] - w_byp - CW'(1))] <= wb_rd[i*RD_W +: RD_W];
                r_mem_data[r_tail + AW'(w_need[i] - w_byp - CW'(1))] <= wb_data[i*XLEN +: XLEN];
            end
        end
    end
    assign occupancy = r_occ;
    assign idle = (r_occ == '0) && !(|wb_valid);
endmodule
